// File: rtl/bob_pkg.sv
// Shared types and constants for the branch ordering buffer sequencing controller.
package bob_pkg;

    localparam int PC_W_DEF     = 64;
    localparam int BHR_W_DEF    = 12;
    localparam int LH_W_DEF     = 10;
    localparam int RAS_W_DEF    = 4;
    localparam int DRAIN_DEF    = 3;
    localparam int DRAIN_CNT_W  = 4;

    localparam logic [PC_W_DEF-1:0] PC_INC = 64'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECOVER = 2'd1,
        ST_DRAIN   = 2'd2
    } state_e;

    // Head-of-BOB checkpoint captured on a mispredict and replayed during recovery.
    typedef struct packed {
        logic [PC_W_DEF-1:0]  pc;
        logic [BHR_W_DEF-1:0] bhr;
        logic [LH_W_DEF-1:0]  lochist;
        logic [RAS_W_DEF-1:0] rasptr;
        logic                 ch_we;
        logic                 ch_dir;
    } ckpt_t;

endpackage

// File: rtl/bob_ctrl.sv
// BOB sequencing controller: write/read arbitration, predictor update pulses and
// mispredict recovery (redirect, restore, flush, then a fixed fetch-hold window).
module bob_ctrl
    import bob_pkg::*;
#(
    parameter int PC_W         = PC_W_DEF,
    parameter int BHR_W        = BHR_W_DEF,
    parameter int LH_W         = LH_W_DEF,
    parameter int RAS_W        = RAS_W_DEF,
    parameter int DRAIN_CYCLES = DRAIN_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             fetch_br_i,
    input  logic             bob_stall_i,
    input  logic             bob_valid_i,
    input  logic [PC_W-1:0]  bob_pc_i,
    input  logic             bob_brdir_i,
    input  logic             bob_ch_we_i,
    input  logic             bob_ch_dir_i,
    input  logic [LH_W-1:0]  bob_lochist_i,
    input  logic [BHR_W-1:0] bob_bhr_i,
    input  logic [RAS_W-1:0] bob_rasptr_i,
    input  logic             ex_res_valid_i,
    input  logic             ex_res_taken_i,
    input  logic [PC_W-1:0]  ex_res_target_i,
    output logic             bob_we_o,
    output logic             bob_re_o,
    output logic             bob_flush_o,
    output logic             ex_res_ready_o,
    output logic             fetch_stall_o,
    output logic             pipe_flush_o,
    output logic             redirect_valid_o,
    output logic [PC_W-1:0]  redirect_pc_o,
    output logic             restore_valid_o,
    output logic [BHR_W-1:0] restore_bhr_o,
    output logic [LH_W-1:0]  restore_lochist_o,
    output logic [RAS_W-1:0] restore_rasptr_o,
    output logic             pht_upd_valid_o,
    output logic [PC_W-1:0]  pht_upd_pc_o,
    output logic             pht_upd_taken_o,
    output logic             choice_upd_valid_o,
    output logic             choice_upd_dir_o,
    output logic             err_underflow_o
);

    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LD = DRAIN_CNT_W'(DRAIN_CYCLES);

    state_e                 state_q, state_d;
    logic [DRAIN_CNT_W-1:0] drain_q, drain_d;
    ckpt_t                  ckpt_q, ckpt_d;
    logic                   taken_q, taken_d;
    logic [PC_W-1:0]        target_q, target_d;
    logic                   pht_v_q, pht_v_d;
    logic [PC_W-1:0]        pht_pc_q, pht_pc_d;
    logic                   pht_taken_q, pht_taken_d;
    logic                   ch_v_q, ch_v_d;
    logic                   ch_dir_q, ch_dir_d;
    logic                   err_q, err_d;

    // Handshake terms are qualified by reset so nothing leaks out while reset is held.
    logic fetch_s;
    logic res_s;
    logic accept_s;
    assign fetch_s  = fetch_br_i & reset_n;
    assign res_s    = ex_res_valid_i & reset_n;
    assign accept_s = res_s & bob_valid_i;

    // State, checkpoint and pulse registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            drain_q     <= '0;
            ckpt_q      <= '0;
            taken_q     <= 1'b0;
            target_q    <= '0;
            pht_v_q     <= 1'b0;
            pht_pc_q    <= '0;
            pht_taken_q <= 1'b0;
            ch_v_q      <= 1'b0;
            ch_dir_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            ckpt_q      <= ckpt_d;
            taken_q     <= taken_d;
            target_q    <= target_d;
            pht_v_q     <= pht_v_d;
            pht_pc_q    <= pht_pc_d;
            pht_taken_q <= pht_taken_d;
            ch_v_q      <= ch_v_d;
            ch_dir_q    <= ch_dir_d;
            err_q       <= err_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d            = state_q;
        drain_d            = drain_q;
        ckpt_d             = ckpt_q;
        taken_d            = taken_q;
        target_d           = target_q;
        pht_v_d            = 1'b0;
        pht_pc_d           = '0;
        pht_taken_d        = 1'b0;
        ch_v_d             = 1'b0;
        ch_dir_d           = 1'b0;
        err_d              = err_q;

        bob_we_o           = 1'b0;
        bob_re_o           = 1'b0;
        bob_flush_o        = 1'b0;
        ex_res_ready_o     = 1'b0;
        fetch_stall_o      = 1'b0;
        pipe_flush_o       = 1'b0;
        redirect_valid_o   = 1'b0;
        redirect_pc_o      = '0;
        restore_valid_o    = 1'b0;
        restore_bhr_o      = '0;
        restore_lochist_o  = '0;
        restore_rasptr_o   = '0;
        pht_upd_valid_o    = 1'b0;
        pht_upd_pc_o       = '0;
        pht_upd_taken_o    = 1'b0;
        choice_upd_valid_o = 1'b0;
        choice_upd_dir_o   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ex_res_ready_o     = accept_s;
                bob_re_o           = accept_s;
                bob_we_o           = fetch_s & ~bob_stall_i & ~accept_s;
                fetch_stall_o      = fetch_s & (bob_stall_i | accept_s);
                pht_upd_valid_o    = pht_v_q;
                pht_upd_pc_o       = pht_pc_q;
                pht_upd_taken_o    = pht_taken_q;
                choice_upd_valid_o = ch_v_q;
                choice_upd_dir_o   = ch_dir_q;
                if (accept_s) begin
                    if (ex_res_taken_i == bob_brdir_i) begin
                        pht_v_d     = 1'b1;
                        pht_pc_d    = bob_pc_i;
                        pht_taken_d = ex_res_taken_i;
                        ch_v_d      = bob_ch_we_i;
                        ch_dir_d    = bob_ch_dir_i;
                    end else begin
                        ckpt_d.pc      = bob_pc_i;
                        ckpt_d.bhr     = bob_bhr_i;
                        ckpt_d.lochist = bob_lochist_i;
                        ckpt_d.rasptr  = bob_rasptr_i;
                        ckpt_d.ch_we   = bob_ch_we_i;
                        ckpt_d.ch_dir  = bob_ch_dir_i;
                        taken_d        = ex_res_taken_i;
                        target_d       = ex_res_target_i;
                        state_d        = ST_RECOVER;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
                if (res_s && !bob_valid_i) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
            end
            ST_RECOVER: begin
                fetch_stall_o      = 1'b1;
                redirect_valid_o   = 1'b1;
                restore_valid_o    = 1'b1;
                pipe_flush_o       = 1'b1;
                bob_flush_o        = 1'b1;
                redirect_pc_o      = taken_q ? target_q : (ckpt_q.pc + PC_INC);
                restore_bhr_o      = {ckpt_q.bhr[BHR_W-2:0], taken_q};
                restore_lochist_o  = {ckpt_q.lochist[LH_W-2:0], taken_q};
                restore_rasptr_o   = ckpt_q.rasptr;
                pht_upd_valid_o    = 1'b1;
                pht_upd_pc_o       = ckpt_q.pc;
                pht_upd_taken_o    = taken_q;
                choice_upd_valid_o = ckpt_q.ch_we;
                choice_upd_dir_o   = ckpt_q.ch_dir;
                drain_d            = DRAIN_LD;
                state_d            = ST_DRAIN;
            end
            ST_DRAIN: begin
                fetch_stall_o = 1'b1;
                if (drain_q <= 4'd1) begin
                    drain_d = 4'd0;
                    state_d = ST_IDLE;
                end else begin
                    drain_d = drain_q - 4'd1;
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                drain_d = 4'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign err_underflow_o = err_q;

endmodule

// File: tb/tb_bob_ctrl.sv
// Directed bench for bob_ctrl; predictor-update and recovery pulses are checked
// against a queue of expected responses by an independent monitor.
module tb_bob_ctrl;

    localparam int PC_W  = 64;
    localparam int BHR_W = 12;
    localparam int LH_W  = 10;
    localparam int RAS_W = 4;

    logic             clock;
    logic             reset_n;
    logic             fetch_br_i;
    logic             bob_stall_i;
    logic             bob_valid_i;
    logic [PC_W-1:0]  bob_pc_i;
    logic             bob_brdir_i;
    logic             bob_ch_we_i;
    logic             bob_ch_dir_i;
    logic [LH_W-1:0]  bob_lochist_i;
    logic [BHR_W-1:0] bob_bhr_i;
    logic [RAS_W-1:0] bob_rasptr_i;
    logic             ex_res_valid_i;
    logic             ex_res_taken_i;
    logic [PC_W-1:0]  ex_res_target_i;
    logic             bob_we_o;
    logic             bob_re_o;
    logic             bob_flush_o;
    logic             ex_res_ready_o;
    logic             fetch_stall_o;
    logic             pipe_flush_o;
    logic             redirect_valid_o;
    logic [PC_W-1:0]  redirect_pc_o;
    logic             restore_valid_o;
    logic [BHR_W-1:0] restore_bhr_o;
    logic [LH_W-1:0]  restore_lochist_o;
    logic [RAS_W-1:0] restore_rasptr_o;
    logic             pht_upd_valid_o;
    logic [PC_W-1:0]  pht_upd_pc_o;
    logic             pht_upd_taken_o;
    logic             choice_upd_valid_o;
    logic             choice_upd_dir_o;
    logic             err_underflow_o;

    bob_ctrl #(.PC_W(PC_W), .BHR_W(BHR_W), .LH_W(LH_W), .RAS_W(RAS_W), .DRAIN_CYCLES(3)) dut (
        .clock(clock), .reset_n(reset_n),
        .fetch_br_i(fetch_br_i), .bob_stall_i(bob_stall_i), .bob_valid_i(bob_valid_i),
        .bob_pc_i(bob_pc_i), .bob_brdir_i(bob_brdir_i), .bob_ch_we_i(bob_ch_we_i),
        .bob_ch_dir_i(bob_ch_dir_i), .bob_lochist_i(bob_lochist_i), .bob_bhr_i(bob_bhr_i),
        .bob_rasptr_i(bob_rasptr_i), .ex_res_valid_i(ex_res_valid_i),
        .ex_res_taken_i(ex_res_taken_i), .ex_res_target_i(ex_res_target_i),
        .bob_we_o(bob_we_o), .bob_re_o(bob_re_o), .bob_flush_o(bob_flush_o),
        .ex_res_ready_o(ex_res_ready_o), .fetch_stall_o(fetch_stall_o),
        .pipe_flush_o(pipe_flush_o), .redirect_valid_o(redirect_valid_o),
        .redirect_pc_o(redirect_pc_o), .restore_valid_o(restore_valid_o),
        .restore_bhr_o(restore_bhr_o), .restore_lochist_o(restore_lochist_o),
        .restore_rasptr_o(restore_rasptr_o), .pht_upd_valid_o(pht_upd_valid_o),
        .pht_upd_pc_o(pht_upd_pc_o), .pht_upd_taken_o(pht_upd_taken_o),
        .choice_upd_valid_o(choice_upd_valid_o), .choice_upd_dir_o(choice_upd_dir_o),
        .err_underflow_o(err_underflow_o)
    );

    typedef struct {
        logic             redirect;
        logic [PC_W-1:0]  pc;
        logic             taken;
        logic             ch_v;
        logic             ch_dir;
        logic [PC_W-1:0]  rd_pc;
        logic [BHR_W-1:0] bhr;
        logic [LH_W-1:0]  lh;
        logic [RAS_W-1:0] ras;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic idle_inputs();
        fetch_br_i = 1'b0; bob_stall_i = 1'b0; bob_valid_i = 1'b0; bob_pc_i = 64'd0;
        bob_brdir_i = 1'b0; bob_ch_we_i = 1'b0; bob_ch_dir_i = 1'b0; bob_lochist_i = 10'd0;
        bob_bhr_i = 12'd0; bob_rasptr_i = 4'd0; ex_res_valid_i = 1'b0; ex_res_taken_i = 1'b0;
        ex_res_target_i = 64'd0;
    endtask

    task automatic resolve(input logic [PC_W-1:0] pc, input logic brdir, input logic taken,
                           input logic [PC_W-1:0] tgt, input logic [BHR_W-1:0] bhr,
                           input logic [LH_W-1:0] lh, input logic [RAS_W-1:0] ras,
                           input logic ch_we, input logic ch_dir);
        bob_valid_i = 1'b1; ex_res_valid_i = 1'b1; bob_pc_i = pc; bob_brdir_i = brdir;
        ex_res_taken_i = taken; ex_res_target_i = tgt; bob_bhr_i = bhr; bob_lochist_i = lh;
        bob_rasptr_i = ras; bob_ch_we_i = ch_we; bob_ch_dir_i = ch_dir;
    endtask

    // Monitor: every update or redirect pulse must match the oldest expected response.
    always @(negedge clock) begin
        if (pht_upd_valid_o || redirect_valid_o) begin
            if (exp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_pulse: got pht=%0b redirect=%0b expected none", pht_upd_valid_o, redirect_valid_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pht_valid", {63'd0, pht_upd_valid_o}, 64'd1);
                chk("pht_pc", pht_upd_pc_o, e.pc);
                chk("pht_taken", {63'd0, pht_upd_taken_o}, {63'd0, e.taken});
                chk("choice_valid", {63'd0, choice_upd_valid_o}, {63'd0, e.ch_v});
                if (e.ch_v) chk("choice_dir", {63'd0, choice_upd_dir_o}, {63'd0, e.ch_dir});
                chk("redirect_valid", {63'd0, redirect_valid_o}, {63'd0, e.redirect});
                chk("restore_valid", {63'd0, restore_valid_o}, {63'd0, e.redirect});
                chk("flushes", {62'd0, bob_flush_o, pipe_flush_o}, {62'd0, e.redirect, e.redirect});
                if (e.redirect) begin
                    chk("redirect_pc", redirect_pc_o, e.rd_pc);
                    chk("restore_bhr", {52'd0, restore_bhr_o}, {52'd0, e.bhr});
                    chk("restore_lochist", {54'd0, restore_lochist_o}, {54'd0, e.lh});
                    chk("restore_rasptr", {60'd0, restore_rasptr_o}, {60'd0, e.ras});
                    chk("recover_no_handshake", {61'd0, bob_we_o, bob_re_o, ex_res_ready_o}, 64'd0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] all_out;
        int          stalls;
        int          writes_in_hold;
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        all_out = {bob_we_o, bob_re_o, bob_flush_o, ex_res_ready_o, fetch_stall_o, pipe_flush_o,
                   redirect_valid_o, restore_valid_o, pht_upd_valid_o, choice_upd_valid_o,
                   err_underflow_o, 21'd0};
        chk("reset_outputs", {32'd0, all_out}, 64'd0);
        reset_n = 1'b1;

        // Fetch-only writes
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1 fetch_br_i = 1'b1;
            @(negedge clock);
            chk("fetch_we", {63'd0, bob_we_o}, 64'd1);
            chk("fetch_nostall", {63'd0, fetch_stall_o}, 64'd0);
        end

        // BOB full
        @(posedge clock); #1 bob_stall_i = 1'b1;
        @(negedge clock);
        chk("full_we", {63'd0, bob_we_o}, 64'd0);
        chk("full_stall", {63'd0, fetch_stall_o}, 64'd1);

        // Same-cycle write and correct not-taken resolve: resolve wins
        @(posedge clock); #1 idle_inputs(); fetch_br_i = 1'b1;
        resolve(64'h2000, 1'b0, 1'b0, 64'h0, 12'h0, 10'h0, 4'h0, 1'b0, 1'b0);
        exp_q.push_back('{1'b0, 64'h2000, 1'b0, 1'b0, 1'b0, 64'h0, 12'h0, 10'h0, 4'h0});
        @(negedge clock);
        chk("same_re", {63'd0, bob_re_o}, 64'd1);
        chk("same_ready", {63'd0, ex_res_ready_o}, 64'd1);
        chk("same_we", {63'd0, bob_we_o}, 64'd0);
        chk("same_stall", {63'd0, fetch_stall_o}, 64'd1);

        // Correct taken prediction with choice update
        @(posedge clock); #1 idle_inputs();
        resolve(64'h1000, 1'b1, 1'b1, 64'h4000, 12'h0, 10'h0, 4'h0, 1'b1, 1'b0);
        exp_q.push_back('{1'b0, 64'h1000, 1'b1, 1'b1, 1'b0, 64'h0, 12'h0, 10'h0, 4'h0});
        @(posedge clock); #1 idle_inputs();
        repeat (2) @(posedge clock);

        // Mispredict predicted-taken / actual not-taken at the top of the address space
        #1 resolve(64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, 64'h5555, 12'h0A5, 10'h155, 4'h7, 1'b1, 1'b1);
        exp_q.push_back('{1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b1, 1'b1, 64'h0, 12'h14A, 10'h2AA, 4'h7});
        @(posedge clock); #1 idle_inputs(); fetch_br_i = 1'b1;
        stalls = 0; writes_in_hold = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (fetch_stall_o) stalls++;
            if (fetch_stall_o && bob_we_o) writes_in_hold++;
        end
        chk("drain_stall_cycles", 64'(stalls), 64'd4);
        chk("hold_no_write", 64'(writes_in_hold), 64'd0);
        chk("post_drain_we", {63'd0, bob_we_o}, 64'd1);

        // Mispredict predicted-not-taken / actual taken to a far target
        @(posedge clock); #1 idle_inputs();
        resolve(64'h8000, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_1234, 12'hFFF, 10'h000, 4'hA, 1'b0, 1'b1);
        exp_q.push_back('{1'b1, 64'h8000, 1'b1, 1'b0, 1'b0, 64'hDEAD_BEEF_0000_1234, 12'hFFF, 10'h001, 4'hA});
        @(posedge clock); #1 idle_inputs();
        repeat (6) @(posedge clock);

        // Underflow: resolution with an empty BOB
        #1 ex_res_valid_i = 1'b1;
        @(negedge clock);
        chk("underflow_not_ready", {63'd0, ex_res_ready_o}, 64'd0);
        @(posedge clock); #1 idle_inputs();
        @(negedge clock);
        chk("underflow_set", {63'd0, err_underflow_o}, 64'd1);
        repeat (3) @(negedge clock);
        chk("underflow_sticky", {63'd0, err_underflow_o}, 64'd1);

        // Reset in the middle of DRAIN
        @(posedge clock); #1 resolve(64'h3000, 1'b1, 1'b0, 64'h0, 12'h001, 10'h001, 4'h1, 1'b0, 1'b0);
        exp_q.push_back('{1'b1, 64'h3000, 1'b0, 1'b0, 1'b0, 64'h3004, 12'h002, 10'h002, 4'h1});
        @(posedge clock); #1 idle_inputs(); fetch_br_i = 1'b1;
        @(posedge clock); #1;
        chk("in_drain_stall", {63'd0, fetch_stall_o}, 64'd1);
        reset_n = 1'b0;
        #1;
        all_out = {bob_we_o, bob_re_o, bob_flush_o, ex_res_ready_o, fetch_stall_o, pipe_flush_o,
                   redirect_valid_o, restore_valid_o, pht_upd_valid_o, choice_upd_valid_o,
                   err_underflow_o, 21'd0};
        chk("reset_mid_drain", {32'd0, all_out}, 64'd0);
        @(negedge clock); reset_n = 1'b1;
        @(negedge clock);
        chk("after_reset_idle_we", {63'd0, bob_we_o}, 64'd1);
        chk("after_reset_nostall", {63'd0, fetch_stall_o}, 64'd0);
        chk("after_reset_err", {63'd0, err_underflow_o}, 64'd0);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
